note_mixer: RTL and testbench

Downstream stage of the note voices: collects samples from `NUM_VOICES` note generators over a per-voice valid/ack handshake and holds the latest sample of each voice. Once per output sample period it sums all enabled voices into one mixed sample for the audio output (PWM/DAC) stage. The block also flags voices that failed to deliver a new sample within the period.

---
 rtl/note_mixer.sv | 146 ++++++++++++++
 tb/tb_note_mixer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/note_mixer.sv
// rtl/note_mixer.sv - per-voice sample capture with periodic sequential mix-down
// Holds the latest sample of each note voice and sums the enabled voices once per tick period.
module note_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 8,
  parameter int TICK_DIV   = 2048,
  localparam int OUT_W     = SAMPLE_W + $clog2(NUM_VOICES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_VOICES-1:0]          note_enable,
  input  logic [NUM_VOICES-1:0]          note_valid,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] note_sample,
  output logic [NUM_VOICES-1:0]          agg_ack,
  output logic [OUT_W-1:0]               mix_out,
  output logic                           mix_valid,
  output logic [NUM_VOICES-1:0]          starved
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_OUT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [OUT_W-1:0]      r_acc;
  logic [OUT_W-1:0]      w_acc_nxt;
  logic [OUT_W-1:0]      r_mix;
  logic [OUT_W-1:0]      w_mix_nxt;
  logic                  r_mix_valid;
  logic                  w_mix_valid_nxt;
  logic [SAMPLE_W-1:0]   r_hold [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_ack;
  logic [NUM_VOICES-1:0] r_fresh;
  logic [NUM_VOICES-1:0] r_starved;
  logic [NUM_VOICES-1:0] w_cap;
  logic                  w_tick;
  logic [OUT_W-1:0]      w_sum;

  assign w_tick = (r_cnt == CNT_W'(TICK_DIV - 1));
  // Masking with the registered ack forces a gap cycle between back-to-back captures.
  assign w_cap  = note_enable & note_valid & ~r_ack;
  assign w_sum  = r_acc + OUT_W'(r_hold[r_idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_hold[i] <= '0;
      end
      r_ack     <= '0;
      r_fresh   <= '0;
      r_starved <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (!note_enable[i]) begin
          r_hold[i] <= '0;
        end else if (w_cap[i]) begin
          r_hold[i] <= note_sample[i*SAMPLE_W +: SAMPLE_W];
        end
      end
      r_ack <= w_cap;
      // A capture landing on the tick counts for the closing period and the next one.
      if (w_tick) begin
        r_starved <= note_enable & ~(r_fresh | w_cap);
        r_fresh   <= w_cap;
      end else begin
        r_fresh   <= r_fresh | w_cap;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_acc_nxt       = r_acc;
    w_mix_nxt       = r_mix;
    w_mix_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_nxt = S_SCAN;
          w_idx_nxt   = '0;
          w_acc_nxt   = '0;
        end
      end
      S_SCAN: begin
        w_acc_nxt = w_sum;
        w_idx_nxt = r_idx + IDX_W'(1);
        // The final sum is published on the edge that enters OUT so the strobe lands in OUT.
        if (r_idx == IDX_W'(NUM_VOICES - 1)) begin
          w_mix_nxt       = w_sum;
          w_mix_valid_nxt = 1'b1;
          w_state_nxt     = S_OUT;
        end
      end
      S_OUT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_acc       <= '0;
      r_mix       <= '0;
      r_mix_valid <= 1'b0;
    end else begin
      r_idx       <= w_idx_nxt;
      r_acc       <= w_acc_nxt;
      r_mix       <= w_mix_nxt;
      r_mix_valid <= w_mix_valid_nxt;
    end
  end

  assign agg_ack   = r_ack;
  assign mix_out   = r_mix;
  assign mix_valid = r_mix_valid;
  assign starved   = r_starved;

endmodule

// File: tb/tb_note_mixer.sv
// tb/tb_note_mixer.sv - directed vector bench for note_mixer
// Vector table for whole-period mixes plus hand sequences for scan/tick/reset corners.
module tb_note_mixer;

  localparam int TICK_DIV = 2048;

  logic        clk;
  logic        rst;
  logic [3:0]  note_enable;
  logic [3:0]  note_valid;
  logic [31:0] note_sample;
  logic [3:0]  agg_ack;
  logic [9:0]  mix_out;
  logic        mix_valid;
  logic [3:0]  starved;

  int checks;
  int failures;
  int cyc;
  int last_strobe;
  logic [3:0] ack_seen;

  note_mixer dut (
    .clk         (clk),
    .rst         (rst),
    .note_enable (note_enable),
    .note_valid  (note_valid),
    .note_sample (note_sample),
    .agg_ack     (agg_ack),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .starved     (starved)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle number since reset release; equals the cycle index when sampled at negedge.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  mask;
    logic [31:0] samp;
    logic [9:0]  mix;
    logic [3:0]  stv;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic deliver(input logic [3:0] mask, input logic [31:0] samp);
    logic [3:0] pend;
    pend        = mask & note_enable;
    note_sample = samp;
    note_valid  = pend;
    for (int k = 0; k < 16 && pend != 4'h0; k++) begin
      @(negedge clk);
      ack_seen   = ack_seen | agg_ack;
      pend       = pend & ~agg_ack;
      note_valid = pend;
    end
    check("deliver_done", {28'h0, pend}, 32'h0);
  endtask

  task automatic wait_mix(input int budget, output bit found);
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      ack_seen = ack_seen | agg_ack;
      if (mix_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("strobe_seen", {31'h0, found}, 32'h1);
  endtask

  task automatic wait_cyc(input int target);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 4200; k++) begin
      if (cyc == target) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_cycle", {31'h0, hit}, 32'h1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"}, {28'h0, agg_ack}, 32'h0);
    check({tag, "_mix"}, {22'h0, mix_out}, 32'h0);
    check({tag, "_mv"}, {31'h0, mix_valid}, 32'h0);
    check({tag, "_starved"}, {28'h0, starved}, 32'h0);
  endtask

  initial begin
    bit found;
    checks      = 0;
    failures    = 0;
    ack_seen    = 4'h0;
    rst         = 1'b1;
    note_enable = 4'hF;
    note_valid  = 4'hF;
    note_sample = 32'hFFFF_FFFF;

    vecs[0] = '{en: 4'hF, mask: 4'hF, samp: 32'h281E_140A, mix: 10'd100, stv: 4'h0};
    vecs[1] = '{en: 4'hF, mask: 4'h0, samp: 32'h0000_0000, mix: 10'd100, stv: 4'hF};
    vecs[2] = '{en: 4'hB, mask: 4'hB, samp: 32'h8080_8080, mix: 10'd384, stv: 4'h0};
    vecs[3] = '{en: 4'hF, mask: 4'h5, samp: 32'h0003_0001, mix: 10'd260, stv: 4'hA};
    vecs[4] = '{en: 4'h1, mask: 4'h1, samp: 32'h0000_0007, mix: 10'd7,   stv: 4'h0};
    vecs[5] = '{en: 4'h0, mask: 4'h0, samp: 32'h0000_0000, mix: 10'd0,   stv: 4'h0};

    // Reset state, then constant full-scale valid on every voice.
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    check("ack_c0", {28'h0, agg_ack}, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("ack_toggle", {28'h0, agg_ack}, (c % 2 == 1) ? 32'hF : 32'h0);
    end
    wait_mix(2100, found);
    check("first_strobe_cycle", cyc, 32'd2052);
    check("first_mix", {22'h0, mix_out}, 32'h3FC);
    check("first_starved", {28'h0, starved}, 32'h0);
    last_strobe = cyc;
    @(negedge clk);
    check("strobe_one_cycle", {31'h0, mix_valid}, 32'h0);
    note_valid = 4'h0;

    for (int v = 0; v < 6; v++) begin
      ack_seen    = 4'h0;
      note_enable = vecs[v].en;
      deliver(vecs[v].mask, vecs[v].samp);
      wait_mix(2100, found);
      check("strobe_period", cyc - last_strobe, TICK_DIV);
      last_strobe = cyc;
      check("vec_mix", {22'h0, mix_out}, {22'h0, vecs[v].mix});
      check("vec_starved", {28'h0, starved}, {28'h0, vecs[v].stv});
      check("vec_disabled_ack", {28'h0, ack_seen & ~vecs[v].en}, 32'h0);
    end

    // Capture into voice 3 in the very cycle it is scanned: excluded now, included next period.
    note_enable = 4'hF;
    wait_cyc(last_strobe + TICK_DIV - 1);
    note_sample = 32'h3200_0000;
    note_valid  = 4'h8;
    @(negedge clk);
    check("late_strobe", {31'h0, mix_valid}, 32'h1);
    check("late_mix_excl", {22'h0, mix_out}, 32'd0);
    check("late_starved", {28'h0, starved}, 32'hF);
    check("late_ack", {28'h0, agg_ack}, 32'h8);
    note_valid  = 4'h0;
    last_strobe = cyc;
    wait_mix(2100, found);
    check("late_mix_incl", {22'h0, mix_out}, 32'd50);
    check("late_starved2", {28'h0, starved}, 32'h7);
    last_strobe = cyc;

    // Capture on the tick cycle itself keeps that voice off the starved list.
    wait_cyc(last_strobe + TICK_DIV - 5);
    note_sample = 32'h0000_0900;
    note_valid  = 4'h2;
    @(negedge clk);
    check("tick_ack", {28'h0, agg_ack}, 32'h2);
    note_valid = 4'h0;
    wait_mix(2100, found);
    check("tick_period", cyc - last_strobe, TICK_DIV);
    check("tick_mix", {22'h0, mix_out}, 32'd59);
    check("tick_starved", {28'h0, starved}, 32'hD);
    last_strobe = cyc;
    wait_mix(2100, found);
    check("tick_mix2", {22'h0, mix_out}, 32'd59);
    check("tick_starved2", {28'h0, starved}, 32'hD);
    last_strobe = cyc;

    // Asynchronous reset two cycles into SCAN.
    wait_cyc(last_strobe + TICK_DIV - 3);
    rst = 1'b1;
    #1;
    check_outputs_zero("midscan");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midscan_no_strobe", {31'h0, mix_valid}, 32'h0);
    end
    rst = 1'b0;
    wait_mix(2100, found);
    check("post_reset_strobe_cycle", cyc, 32'd2052);
    check("post_reset_mix", {22'h0, mix_out}, 32'd0);
    check("post_reset_starved", {28'h0, starved}, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
